rr_arbiter_4ch_encoded: RTL
===========================

// Module: rr_arbiter_4ch_encoded
// PURPOSE
//   Round-robin arbiter that shares one 4-input resource among four requesters.
//   Issues a registered one-hot grant plus its 2-bit binary index. The index
//   has the 4-to-2 encoding that the downstream mux/select path consumes.
//   Sits between the requesters and the shared datapath; owns grant hold/release sequencing.
// PARAMETERS
//   MAX_HOLD   8   max cycles a grant may be held before forced release (ARB_TIMEOUT_EN only); legal 2..255
//   CNT_W      8   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous reset, active-low
//   req        in   4  request vector, req[i] = requester i wants resource (level)
//   done       in   1  single-cycle pulse from current grantee: release grant
//   gnt        out  4  one-hot grant, registered
//   gnt_idx    out  2  binary index of granted requester (0..3), registered
//   gnt_valid  out  1  high while any grant is active (== |gnt)
//   timeout    out  1  one-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//   Reset (async assert, sync deassert by clk): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0,
//     state=IDLE, last_ptr=3 (so req[0] has top priority first), hold_cnt=0.
//   FSM: IDLE, GRANT, RELEASE.
//   IDLE: if |req, pick winner = first set bit scanning (last_ptr+1) mod 4 upward,
//     wrapping 3->0. Next cycle: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1,
//     last_ptr=winner, hold_cnt=0, ->GRANT. Latency req->gnt = 1 cycle. No req: stay IDLE.
//   GRANT: grant is stable; ignore changes on other req bits.
//     Release when done=1 OR req[gnt_idx]=0 (requester withdrew) -> RELEASE.
//     done while req[gnt_idx]=0 is one release, not two.
//     hold_cnt increments each GRANT cycle, saturates at MAX_HOLD.
//   RELEASE: gnt=0, gnt_valid=0, gnt_idx holds last value; exactly one dead cycle.
//     Always ->IDLE, giving a guaranteed non-overlapping handover.
//   Handover: min spacing between two grants = 2 idle-grant cycles (RELEASE + IDLE).
//     Back-to-back requester i is re-granted only after all other pending requesters.
//   done in IDLE or RELEASE: ignored. req bits only matter in IDLE and for the grantee.
//   gnt_valid == |gnt at all times; gnt never has >1 bit set.
//   Fairness: with all 4 req held high, grants go 0,1,2,3,0,... in that order.
//   Reset mid-grant: all outputs drop asynchronously; arbitration restarts at req[0] priority.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: when hold_cnt reaches MAX_HOLD-1 in GRANT without release,
//     the next edge forces GRANT->RELEASE and pulses timeout=1 for that cycle
//     (coincident with gnt dropping). Grant length is therefore <= MAX_HOLD cycles.
//     A done on the same cycle as expiry is a normal release: timeout stays 0.
//   ARB_TIMEOUT_EN undefined: no counter logic; grant is held until done or req drop,
//     with no upper bound; timeout tied 0.
// TESTING
//   Reset: rst_n=0 mid-grant -> gnt=0, gnt_valid=0, gnt_idx=0 immediately (no clk edge).
//   req=4'b1010 from reset -> cycle+1 gnt=4'b0010, gnt_idx=1. done pulse -> RELEASE.
//     Then gnt=4'b1000, gnt_idx=3 two cycles after release.
//   req=4'b1111 held, done pulsed 2 cycles into each grant -> gnt_idx sequence 0,1,2,3,0.
//     Each grant is separated by exactly 2 gnt_valid=0 cycles.
//   Grantee withdrawal: grant on 2, drop req[2] -> gnt=0 next cycle, timeout=0.
//     Other req changes during the grant do not disturb gnt.
//   ARB_TIMEOUT_EN, MAX_HOLD=8: req=4'b0100 held, no done -> gnt_valid high exactly 8 cycles.
//     timeout=1 for 1 cycle. Then regrant to 2 (sole requester). Without macro: held 100+ cycles.
//   Check every cycle: $onehot0(gnt), gnt_valid==|gnt, gnt[gnt_idx]==1 when gnt_valid.

Source files
------------

// File: rtl/rr_arbiter_4ch_encoded.sv
// Round-robin arbiter for 4 requesters: registered one-hot grant plus 2-bit index, one dead cycle between grants.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4ch_encoded #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state, state_nxt;
  logic [1:0] last_ptr, last_ptr_nxt;
  logic [1:0] gnt_idx_nxt;
  logic [3:0] gnt_nxt;
  logic       timeout_nxt;
  logic [1:0] winner, cand;
  logic       found;
  logic       release_req;
  logic       expire;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter_4ch_encoded: illegal MAX_HOLD/CNT_W combination");
  end

  // Scan upward from the slot after the last winner, wrapping 3->0.
  always_comb begin
    winner = last_ptr;
    found  = 1'b0;
    cand   = last_ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = last_ptr + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign release_req = done || !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign expire = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gnt_idx_nxt  = gnt_idx;
    last_ptr_nxt = last_ptr;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt      = 4'b0001 << winner;
          gnt_idx_nxt  = winner;
          last_ptr_nxt = winner;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        // A genuine release wins over expiry, so timeout only flags forced drops.
        if (release_req || expire) begin
          gnt_nxt     = 4'b0000;
          timeout_nxt = !release_req && expire;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        gnt_nxt   = 4'b0000;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 4'b0000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      last_ptr <= 2'd3;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= gnt_idx_nxt;
      last_ptr <= last_ptr_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule
